// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard scan-code sequencer.
// Holds the FSM state encoding, prefix/status byte values and the event record.
package ps2_kbd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StPause
    } state_e;

    localparam logic [7:0] ByteE0 = 8'hE0;
    localparam logic [7:0] ByteF0 = 8'hF0;
    localparam logic [7:0] ByteE1 = 8'hE1;

    // E1 prefix is followed by seven more bytes in the pause sequence.
    localparam logic [2:0] PauseLen = 3'd7;

    typedef struct packed {
        logic       rep;
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    function automatic logic is_status(input logic [7:0] b);
        logic r;
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Byte-in / event-out bundle of the keyboard sequencer.
// master = byte source plus event consumer, slave = the sequencer itself.
interface ps2_kbd_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       ovf_clr;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       evt_rep;
    logic       held;
    logic [8:0] held_code;
    logic [7:0] press_cnt;
    logic       overflow;

    modport master (
        output rx_valid, rx_data, rd_en, ovf_clr,
        input  evt_valid, evt_code, evt_ext, evt_brk, evt_rep,
        input  held, held_code, press_cnt, overflow
    );

    modport slave (
        input  rx_valid, rx_data, rd_en, ovf_clr,
        output evt_valid, evt_code, evt_ext, evt_brk, evt_rep,
        output held, held_code, press_cnt, overflow
    );
endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle, otherwise it is reported as a drop.
module ps2_evt_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  evt_t wdata,
    output evt_t rdata,
    output logic full,
    output logic empty,
    output logic drop
);

    localparam logic [AW:0] FullCnt = DEPTH[AW:0];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    evt_t          mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    always_comb begin
        full    = (count_q == FullCnt);
        empty   = (count_q == '0);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        drop    = push & full & ~do_pop;
        rdata   = empty ? '0 : mem_q[rd_ptr_q];

        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencer: folds E0/F0/E1 prefixes into key events, drops status
// bytes, flags typematic repeats and tracks held-key / press-count status.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic         clk,
    input  logic         resetn,
    ps2_kbd_ctrl_if.slave bus
);

    state_e     state_q, state_d;
    logic [2:0] pause_cnt_q, pause_cnt_d;
    logic       held_q, held_d;
    logic [8:0] held_code_q, held_code_d;
    logic [7:0] press_cnt_q, press_cnt_d;
    logic       overflow_q, overflow_d;

    logic emit_make;
    logic emit_brk;
    logic emit_ext;
    logic emit_pause;

    evt_t       evt;
    logic [8:0] key;
    logic       push;
    logic       drop;
    evt_t       head;
    logic       fifo_full;
    logic       fifo_empty;

    // Sequencer FSM: moves only on rx_valid cycles.
    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        emit_make   = 1'b0;
        emit_brk    = 1'b0;
        emit_ext    = 1'b0;
        emit_pause  = 1'b0;
        if (bus.rx_valid) begin
            case (state_q)
                StIdle: begin
                    if (bus.rx_data == ByteE0) begin
                        state_d = StExt;
                    end else if (bus.rx_data == ByteF0) begin
                        state_d = StBrk;
                    end else if (bus.rx_data == ByteE1) begin
                        state_d     = StPause;
                        pause_cnt_d = PauseLen;
                    end else if (!is_status(bus.rx_data)) begin
                        emit_make = 1'b1;
                    end
                end
                StExt: begin
                    if (bus.rx_data == ByteF0) begin
                        state_d = StExtBrk;
                    end else if (bus.rx_data != ByteE0) begin
                        emit_make = 1'b1;
                        emit_ext  = 1'b1;
                        state_d   = StIdle;
                    end
                end
                StBrk, StExtBrk: begin
                    state_d = StIdle;
                    // A second prefix here is a protocol error: abandon silently.
                    if (bus.rx_data != ByteF0 && bus.rx_data != ByteE0) begin
                        emit_brk = 1'b1;
                        emit_ext = (state_q == StExtBrk);
                    end
                end
                StPause: begin
                    pause_cnt_d = pause_cnt_q - 3'd1;
                    if (pause_cnt_q == 3'd1) begin
                        state_d    = StIdle;
                        emit_make  = 1'b1;
                        emit_pause = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Event record and held-key / press-count status.
    always_comb begin
        evt.code = emit_pause ? ByteE1 : bus.rx_data;
        evt.ext  = emit_ext;
        evt.brk  = emit_brk;
        key      = {emit_ext, evt.code};
        evt.rep  = emit_make & ~emit_pause & held_q & (key == held_code_q);
        push     = emit_make | emit_brk;

        held_d      = held_q;
        held_code_d = held_code_q;
        press_cnt_d = press_cnt_q;
        if (emit_make && !evt.rep) begin
            held_d      = 1'b1;
            held_code_d = key;
            press_cnt_d = press_cnt_q + 8'd1;
        end
        if (emit_brk && key == held_code_q) begin
            held_d = 1'b0;
        end

        // A drop in the same cycle as the clear wins.
        overflow_d = overflow_q;
        if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            pause_cnt_q <= '0;
            held_q      <= 1'b0;
            held_code_q <= '0;
            press_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pause_cnt_q <= pause_cnt_d;
            held_q      <= held_d;
            held_code_q <= held_code_d;
            press_cnt_q <= press_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (bus.rd_en),
        .wdata  (evt),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .drop   (drop)
    );

    assign bus.evt_valid = ~fifo_empty;
    assign bus.evt_code  = head.code;
    assign bus.evt_ext   = head.ext;
    assign bus.evt_brk   = head.brk;
    assign bus.evt_rep   = head.rep;
    assign bus.held      = held_q;
    assign bus.held_code = held_code_q;
    assign bus.press_cnt = press_cnt_q;
    assign bus.overflow  = overflow_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: expected events go into a queue as bytes are
// driven and are compared against the FIFO head as it is drained.
module tb_ps2_kbd_ctrl;
    import ps2_kbd_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic clk;
    logic resetn;
    int   total;
    int   bad;
    evt_t exp_q[$];

    ps2_kbd_ctrl_if bus ();

    ps2_kbd_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic evt_t mk(input logic rep, input logic ext, input logic brk,
                                input logic [7:0] code);
        evt_t e;
        e.rep  = rep;
        e.ext  = ext;
        e.brk  = brk;
        e.code = code;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic drain(input string tag);
        evt_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, ".valid"}, 32'(bus.evt_valid), 32'd1);
            check({tag, ".evt"},
                  32'({bus.evt_rep, bus.evt_ext, bus.evt_brk, bus.evt_code}), 32'(e));
            bus.rd_en = 1'b1;
            @(posedge clk);
            #1;
            bus.rd_en = 1'b0;
        end
        check({tag, ".empty"}, 32'(bus.evt_valid), 32'd0);
    endtask

    initial begin
        evt_t e;
        total        = 0;
        bad          = 0;
        resetn       = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rd_en    = 1'b0;
        bus.ovf_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 32'(bus.evt_valid), 32'd0);
        check("rst.code", 32'(bus.evt_code), 32'd0);
        check("rst.held", 32'(bus.held), 32'd0);
        check("rst.held_code", 32'(bus.held_code), 32'd0);
        check("rst.press", 32'(bus.press_cnt), 32'd0);
        check("rst.ovf", 32'(bus.overflow), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // make then break of a plain key
        send(8'h1C); exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h1C));
        check("t1.held_mk", 32'(bus.held), 32'd1);
        check("t1.valid_now", 32'(bus.evt_valid), 32'd1);
        send(8'hF0);
        send(8'h1C); exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 8'h1C));
        check("t1.held_brk", 32'(bus.held), 32'd0);
        check("t1.press", 32'(bus.press_cnt), 32'd1);
        check("t1.held_code", 32'(bus.held_code), 32'h01C);
        drain("t1");

        // extended make / break
        send(8'hE0);
        send(8'h75); exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 8'h75));
        check("t2.held_mk", 32'(bus.held), 32'd1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75); exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 8'h75));
        check("t2.held_code", 32'(bus.held_code), 32'h175);
        check("t2.held", 32'(bus.held), 32'd0);
        check("t2.press", 32'(bus.press_cnt), 32'd2);
        drain("t2");

        // typematic repeats
        send(8'h1C); exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h1C));
        send(8'h1C); exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h1C));
        send(8'h1C); exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h1C));
        check("t3.press_rep", 32'(bus.press_cnt), 32'd3);
        send(8'hF0);
        send(8'h1C); exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 8'h1C));
        check("t3.held", 32'(bus.held), 32'd0);
        check("t3.count", 32'(exp_q.size()), 32'd4);
        drain("t3");

        // status bytes dropped, pause sequence collapses to one event
        send(8'hAA);
        send(8'hFA);
        check("t4.status", 32'(bus.evt_valid), 32'd0);
        send(8'hE1);
        send(8'h14);
        send(8'h77);
        send(8'hE1);
        send(8'hF0);
        send(8'h14);
        send(8'hF0);
        check("t4.pause_mid", 32'(bus.evt_valid), 32'd0);
        send(8'h77); exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE1));
        check("t4.pause_end", 32'(bus.evt_valid), 32'd1);
        send(8'h1C); exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h1C));
        drain("t4");

        // overflow: DEPTH+2 makes with no reader
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            send(8'(8'h20 + i));
            if (i < DEPTH) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'(8'h20 + i)));
        end
        check("t5.ovf", 32'(bus.overflow), 32'd1);
        check("t5.press", 32'(bus.press_cnt), 32'(DEPTH + 2));
        // push and pop together while full: push accepted
        e = exp_q.pop_front();
        check("t5.head", 32'({bus.evt_rep, bus.evt_ext, bus.evt_brk, bus.evt_code}), 32'(e));
        bus.rd_en    = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h30;
        @(posedge clk);
        #1;
        bus.rd_en    = 1'b0;
        bus.rx_valid = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h30));
        check("t5.press_pp", 32'(bus.press_cnt), 32'(DEPTH + 3));
        // clear coinciding with a fresh drop keeps the flag
        bus.ovf_clr  = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h31;
        @(posedge clk);
        #1;
        bus.ovf_clr  = 1'b0;
        bus.rx_valid = 1'b0;
        check("t5.ovf_race", 32'(bus.overflow), 32'd1);
        check("t5.press_drop", 32'(bus.press_cnt), 32'(DEPTH + 4));
        check("t5.held_code", 32'(bus.held_code), 32'h031);
        bus.ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.ovf_clr = 1'b0;
        check("t5.ovf_clr", 32'(bus.overflow), 32'd0);
        drain("t5");

        // reset mid-sequence discards prefix and buffered events
        send(8'h40);
        send(8'hE0);
        resetn       = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hF0;
        @(posedge clk);
        #1;
        resetn       = 1'b1;
        bus.rx_valid = 1'b0;
        check("t6.valid", 32'(bus.evt_valid), 32'd0);
        check("t6.held", 32'(bus.held), 32'd0);
        check("t6.held_code", 32'(bus.held_code), 32'd0);
        check("t6.press", 32'(bus.press_cnt), 32'd0);
        send(8'h1C); exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h1C));
        check("t6.press_after", 32'(bus.press_cnt), 32'd1);
        check("t6.held_code_after", 32'(bus.held_code), 32'h01C);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
